// File: rtl/multirate_mac_scheduler_if.sv
// Bundle of the branch request bus, the shared-multiplier port pair and the
// completed-sum output stream of the multirate MAC scheduler.
interface multirate_mac_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int GUARD   = 4
);
    localparam int ACC_W = 26 + GUARD;

    // Branch tap requests, one lane per polyphase branch
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_sample;
    logic [NUM_REQ*10-1:0] req_coef;
    logic [NUM_REQ-1:0]    req_last;

    // Shared combinational 16s x 10u multiplier
    logic [15:0]           mul_din0;
    logic [9:0]            mul_din1;
    logic [25:0]           mul_dout;

    // Completed branch sums
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic [ACC_W-1:0]      out_data;

    // Scheduler side
    modport slave (
        input  req_valid, req_sample, req_coef, req_last, mul_dout, out_ready,
        output req_ready, mul_din0, mul_din1, out_valid, out_id, out_data
    );

    // Environment side: branches, multiplier and downstream consumer
    modport master (
        output req_valid, req_sample, req_coef, req_last, mul_dout, out_ready,
        input  req_ready, mul_din0, mul_din1, out_valid, out_id, out_data
    );
endinterface

// File: rtl/multirate_mac_scheduler.sv
// Round-robin scheduler sharing one 16s x 10u multiplier between NUM_REQ
// polyphase FIR branches. Each branch owns an accumulator; the tap flagged
// with req_last closes the dot product and pushes the sum to the output.
// A pending output that is not accepted freezes the whole pipe.
module multirate_mac_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int GUARD   = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    multirate_mac_scheduler_if.slave bus
);
    localparam int ACC_W = 26 + GUARD;

    logic                    stall;
    logic                    handshake;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         next_ptr;
    logic [ID_W-1:0]         scan_pos;
    logic                    found;
    logic [NUM_REQ-1:0]      grant_vec;
    logic [ID_W-1:0]         grant_id;
    logic [15:0]             grant_sample;
    logic [9:0]              grant_coef;
    logic                    grant_last;

    logic                    s1_valid;
    logic [ID_W-1:0]         s1_id;
    logic [15:0]             s1_sample;
    logic [9:0]              s1_coef;
    logic                    s1_last;

    logic [ACC_W-1:0]        acc [NUM_REQ];
    logic [ACC_W-1:0]        sum;

    assign stall     = bus.out_valid & ~bus.out_ready;
    assign bus.req_ready = (ap_rst_n && !stall) ? grant_vec : '0;
    assign handshake = |(bus.req_valid & bus.req_ready);
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    assign bus.mul_din0 = s1_valid ? s1_sample : '0;
    assign bus.mul_din1 = s1_valid ? s1_coef   : '0;

    // Pick the first valid branch at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found        = 1'b0;
        scan_pos     = '0;
        grant_vec    = '0;
        grant_id     = '0;
        grant_sample = '0;
        grant_coef   = '0;
        grant_last   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[scan_pos]) begin
                found               = 1'b1;
                grant_vec[scan_pos] = 1'b1;
                grant_id            = scan_pos;
                grant_sample        = bus.req_sample[scan_pos*16 +: 16];
                grant_coef          = bus.req_coef[scan_pos*10 +: 10];
                grant_last          = bus.req_last[scan_pos];
            end
        end
    end

    // Running sum of the branch whose product is on the multiplier this cycle
    always_comb begin
        sum = acc[s1_id] + {{GUARD{bus.mul_dout[25]}}, bus.mul_dout};
    end

    // Pointer, operand stage, accumulators and output register; all frozen on stall
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rr_ptr        <= '0;
            s1_valid      <= 1'b0;
            s1_id         <= '0;
            s1_sample     <= '0;
            s1_coef       <= '0;
            s1_last       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_id    <= '0;
            bus.out_data  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc[i] <= '0;
            end
        end else if (!stall) begin
            if (handshake) begin
                rr_ptr    <= next_ptr;
                s1_valid  <= 1'b1;
                s1_id     <= grant_id;
                s1_sample <= grant_sample;
                s1_coef   <= grant_coef;
                s1_last   <= grant_last;
            end else begin
                s1_valid  <= 1'b0;
            end

            bus.out_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    bus.out_valid <= 1'b1;
                    bus.out_id    <= s1_id;
                    bus.out_data  <= sum;
                    acc[s1_id]    <= '0;
                end else begin
                    acc[s1_id]    <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_multirate_mac_scheduler.sv
// Directed self-checking bench for multirate_mac_scheduler. The bench models
// the shared multiplier and checks arbitration order, sums, latency, stall
// behaviour and mid-operation reset against hand-computed values.
module tb_multirate_mac_scheduler;
    logic ap_clk = 1'b0;
    logic ap_rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    multirate_mac_scheduler_if #(.NUM_REQ(4), .ID_W(2), .GUARD(4)) bus ();

    multirate_mac_scheduler #(.NUM_REQ(4), .ID_W(2), .GUARD(4)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    // Clock generation, 10 time-unit period
    always #5 ap_clk = ~ap_clk;

    // Combinational 16s x 10u multiplier model
    logic signed [25:0] product;
    assign product      = $signed(bus.mul_din0) * $signed({1'b0, bus.mul_din1});
    assign bus.mul_dout = product;

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n      = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        tick();
        ap_rst_n = 1'b1;
    endtask

    // Present one tap on branch b, wait (bounded) for its grant, then withdraw it
    task automatic send_tap(input int b, input logic [15:0] s, input logic [9:0] c, input logic l);
        int waited;
        bus.req_valid            = '0;
        bus.req_last             = '0;
        bus.req_valid[b]         = 1'b1;
        bus.req_sample[b*16 +: 16] = s;
        bus.req_coef[b*10 +: 10] = c;
        bus.req_last[b]          = l;
        waited = 0;
        #1;
        while (!bus.req_ready[b] && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        if (waited >= 50) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL grant_timeout branch %0d: got no grant, expected grant within 50 cycles", b);
        end else begin
            tick();
        end
        bus.req_valid[b] = 1'b0;
        bus.req_last[b]  = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n       = 1'b0;
        bus.req_valid  = '1;
        bus.req_sample = '0;
        bus.req_coef   = '0;
        bus.req_last   = '0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_req_ready: got %b, expected 0000", bus.req_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.out_id !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_id: got %0d, expected 0", bus.out_id);
        end
        vectors++;
        if (bus.out_data !== 30'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_data: got %0d, expected 0", bus.out_data);
        end
        vectors++;
        if (bus.mul_din0 !== 16'd0 || bus.mul_din1 !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mul_din: got %h/%h, expected 0000/000", bus.mul_din0, bus.mul_din1);
        end
        bus.req_valid = '0;
        ap_rst_n      = 1'b1;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_req_ready: got %b, expected 0000", bus.req_ready);
        end
    endtask

    task automatic test_single_branch();
        logic signed [29:0] exp_data = 30'sd1800;
        send_tap(0, 16'sd100, 10'd5, 1'b0);
        send_tap(0, -16'sd200, 10'd7, 1'b0);
        send_tap(0, 16'sd300, 10'd9, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_early_valid: got %b, expected 0", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL single_sum: got v=%b id=%0d data=%0d, expected v=1 id=0 data=%0d",
                     bus.out_valid, bus.out_id, $signed(bus.out_data), exp_data);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_valid_clear: got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_all [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] exp_sparse [3] = '{4'b0100, 4'b0001, 4'b0100};
        do_reset();
        bus.req_sample = '0;
        bus.req_coef   = '0;
        bus.req_last   = '0;
        bus.req_valid  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (bus.req_ready !== exp_all[i]) begin
                miscompares++;
                $display("[TB] FAIL rr_all_grant %0d: got %b, expected %b", i, bus.req_ready, exp_all[i]);
            end
            tick();
        end
        bus.req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.req_ready !== exp_sparse[i]) begin
                miscompares++;
                $display("[TB] FAIL rr_sparse_grant %0d: got %b, expected %b", i, bus.req_ready, exp_sparse[i]);
            end
            tick();
        end
        bus.req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_wide_sum();
        logic signed [29:0] exp_data = -30'sd134086656;
        send_tap(2, 16'h8000, 10'h3FF, 1'b0);
        vectors++;
        if (bus.mul_din0 !== 16'h8000 || bus.mul_din1 !== 10'h3FF) begin
            miscompares++;
            $display("[TB] FAIL wide_operands: got %h/%h, expected 8000/3ff", bus.mul_din0, bus.mul_din1);
        end
        send_tap(2, 16'h8000, 10'h3FF, 1'b0);
        send_tap(2, 16'h8000, 10'h3FF, 1'b0);
        send_tap(2, 16'h8000, 10'h3FF, 1'b1);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2 || bus.out_data !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL wide_sum: got v=%b id=%0d data=%0d, expected v=1 id=2 data=%0d",
                     bus.out_valid, bus.out_id, $signed(bus.out_data), exp_data);
        end
        tick();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        send_tap(0, 16'sd7, 10'd3, 1'b1);
        bus.req_valid[1]        = 1'b1;
        bus.req_sample[31:16]   = 16'sd5;
        bus.req_coef[19:10]     = 10'd2;
        bus.req_last[1]         = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL stall_pre_grant: got %b, expected 0010", bus.req_ready);
        end
        tick();
        bus.req_valid[1]      = 1'b0;
        bus.req_last[1]       = 1'b0;
        bus.req_valid[3]      = 1'b1;
        bus.req_sample[63:48] = 16'sd9;
        bus.req_coef[39:30]   = 10'd1;
        bus.req_last[3]       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL stall_req_ready %0d: got %b, expected 0000", i, bus.req_ready);
            end
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 30'd21) begin
                miscompares++;
                $display("[TB] FAIL stall_hold %0d: got v=%b id=%0d data=%0d, expected v=1 id=0 data=21",
                         i, bus.out_valid, bus.out_id, $signed(bus.out_data));
            end
            tick();
        end
        #1;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL stall_resume_grant: got %b, expected 1000", bus.req_ready);
        end
        tick();
        bus.req_valid[3] = 1'b0;
        bus.req_last[3]  = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_data !== 30'd10) begin
            miscompares++;
            $display("[TB] FAIL stall_drain_b1: got v=%b id=%0d data=%0d, expected v=1 id=1 data=10",
                     bus.out_valid, bus.out_id, $signed(bus.out_data));
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd3 || bus.out_data !== 30'd9) begin
            miscompares++;
            $display("[TB] FAIL stall_drain_b3: got v=%b id=%0d data=%0d, expected v=1 id=3 data=9",
                     bus.out_valid, bus.out_id, $signed(bus.out_data));
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_no_duplicate: got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_interleave();
        logic signed [29:0] exp_b3 = -30'sd1000;
        bus.req_valid         = 4'b1010;
        bus.req_sample[31:16] = 16'sd2;
        bus.req_coef[19:10]   = 10'd3;
        bus.req_last          = 4'b1000;
        bus.req_sample[63:48] = -16'sd1;
        bus.req_coef[39:30]   = 10'd1000;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL interleave_grant0: got %b, expected 0010", bus.req_ready);
        end
        tick();
        bus.req_sample[31:16] = 16'sd4;
        bus.req_coef[19:10]   = 10'd5;
        bus.req_last          = 4'b1010;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL interleave_grant1: got %b, expected 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL interleave_grant2: got %b, expected 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd3 || bus.out_data !== exp_b3) begin
            miscompares++;
            $display("[TB] FAIL interleave_b3: got v=%b id=%0d data=%0d, expected v=1 id=3 data=-1000",
                     bus.out_valid, bus.out_id, $signed(bus.out_data));
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_data !== 30'd26) begin
            miscompares++;
            $display("[TB] FAIL interleave_b1: got v=%b id=%0d data=%0d, expected v=1 id=1 data=26",
                     bus.out_valid, bus.out_id, $signed(bus.out_data));
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL interleave_valid_clear: got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        send_tap(0, 16'sd10, 10'd10, 1'b0);
        send_tap(0, 16'sd20, 10'd20, 1'b0);
        ap_rst_n         = 1'b0;
        bus.req_valid[0] = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midreset_req_ready: got %b, expected 0000", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        ap_rst_n      = 1'b1;
        send_tap(0, 16'sd1, 10'd1, 1'b1);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 30'd1) begin
            miscompares++;
            $display("[TB] FAIL midreset_replay: got v=%b id=%0d data=%0d, expected v=1 id=0 data=1",
                     bus.out_valid, bus.out_id, $signed(bus.out_data));
        end
        tick();
    endtask

    // Scenario sequence and summary
    initial begin
        ap_rst_n       = 1'b0;
        bus.req_valid  = '0;
        bus.req_sample = '0;
        bus.req_coef   = '0;
        bus.req_last   = '0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_single_branch();
        test_round_robin();
        test_wide_sum();
        test_stall();
        test_interleave();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
